// File: rtl/vrf_pkg.sv
// Shared types, default sizes and address/lane helpers for the banked vector register file controller.
package vrf_pkg;

  localparam int unsigned NUM_VRS_DEF = 32;
  localparam int unsigned ELEMS_DEF   = 32;
  localparam int unsigned BANKS_DEF   = 4;
  localparam int unsigned DW_DEF      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_DRAIN = 2'd3
  } vrf_state_e;

  // Word address of one beat: each VR occupies 'beats' consecutive words in every bank.
  function automatic int unsigned beat_addr(input int unsigned vr, input int unsigned beat,
                                            input int unsigned beats);
    return vr * beats + beat;
  endfunction

  // Lane k of a beat is live while its element index is below vl.
  function automatic logic [31:0] lane_mask(input int unsigned beat, input int unsigned vl,
                                            input int unsigned banks);
    logic [31:0] m;
    m = '0;
    for (int unsigned k = 0; k < 32; k++)
      m[k] = (k < banks) && ((beat * banks + k) < vl);
    return m;
  endfunction

endpackage

// File: rtl/vrf_rr_arb.sv
// Two-way round-robin arbiter; priority flips to the requester that was not granted.
module vrf_rr_arb (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic prio_q, prio_d;

  always_comb begin
    gnt_o  = '0;
    prio_d = prio_q;
    if (en_i) begin
      gnt_o[0] = req_i[0] && (!prio_q || !req_i[1]);
      gnt_o[1] = req_i[1] && ( prio_q || !req_i[0]);
    end
    if (gnt_o[0])      prio_d = 1'b1;
    else if (gnt_o[1]) prio_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/vrf_ctrl.sv
// Vector register file controller: arbitrates two requesters and streams VR reads/writes across banks.
// Define VRF_CTRL_STATS_EN to add the rd_ops_o / wr_ops_o completed-op counters.
module vrf_ctrl
  import vrf_pkg::*;
#(
  parameter  int unsigned NumVRs     = NUM_VRS_DEF,
  parameter  int unsigned ElemsPerVR = ELEMS_DEF,
  parameter  int unsigned NumBanks   = BANKS_DEF,
  parameter  int unsigned DataWidth  = DW_DEF,
  localparam int unsigned Beats      = ElemsPerVR / NumBanks,
  localparam int unsigned AW         = $clog2(NumVRs * Beats),
  localparam int unsigned VW         = $clog2(NumVRs),
  localparam int unsigned LW         = $clog2(ElemsPerVR) + 1
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic [1:0]                          req_valid_i,
  output logic [1:0]                          req_ready_o,
  input  logic [1:0]                          req_we_i,
  input  logic [1:0][VW-1:0]                  req_vr_i,
  input  logic [1:0][LW-1:0]                  req_vl_i,
  input  logic                                wdata_valid_i,
  output logic                                wdata_ready_o,
  input  logic [NumBanks-1:0][DataWidth-1:0]  wdata_i,
  output logic                                rdata_valid_o,
  output logic                                rdata_last_o,
  output logic                                rdata_id_o,
  output logic [NumBanks-1:0][DataWidth-1:0]  rdata_o,
  output logic [NumBanks-1:0]                 rdata_mask_o,
  output logic                                done_o,
  output logic                                done_id_o,
  output logic [NumBanks-1:0]                 sram_re_o,
  output logic [NumBanks-1:0]                 sram_we_o,
  output logic [NumBanks-1:0][AW-1:0]         sram_r_addr_o,
  output logic [NumBanks-1:0][AW-1:0]         sram_w_addr_o,
  output logic [NumBanks-1:0][DataWidth-1:0]  sram_wdata_o,
  input  logic [NumBanks-1:0][DataWidth-1:0]  sram_rdata_i
`ifdef VRF_CTRL_STATS_EN
  ,
  output logic [31:0]                         rd_ops_o,
  output logic [31:0]                         wr_ops_o
`endif
);

  localparam int unsigned BW = $clog2(Beats) + 1;

  vrf_state_e          state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [VW-1:0]       vr_q;
  logic [LW-1:0]       vl_q;
  logic                id_q;
  logic                skip_done_q, skip_id_q;
  logic                rvld_q, rlast_q, rid_q;
  logic [NumBanks-1:0] rmask_q;

  logic [1:0]          gnt;
  logic                arb_en, accept, sel, acc_skip, last_beat;
  logic [LW-1:0]       vl_clamp;
  logic [NumBanks-1:0] lane_en;
  logic [AW-1:0]       beat_adr;

  assign arb_en = nrst && (state_q == ST_IDLE);

  vrf_rr_arb u_arb (
    .clk   (clk),
    .nrst  (nrst),
    .en_i  (arb_en),
    .req_i (req_valid_i),
    .gnt_o (gnt)
  );

  assign accept   = |gnt;
  assign sel      = gnt[1];
  assign vl_clamp = (req_vl_i[sel] > LW'(ElemsPerVR)) ? LW'(ElemsPerVR) : req_vl_i[sel];
  // Empty or out-of-range ops complete without touching the banks.
  assign acc_skip = (vl_clamp == '0) || (32'(req_vr_i[sel]) >= NumVRs);

  assign lane_en   = NumBanks'(lane_mask(32'(beat_q), 32'(vl_q), NumBanks));
  assign beat_adr  = AW'(beat_addr(32'(vr_q), 32'(beat_q), Beats));
  assign last_beat = ((32'(beat_q) + 32'd1) * NumBanks) >= 32'(vl_q);

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    req_ready_o   = gnt;
    wdata_ready_o = 1'b0;
    sram_re_o     = '0;
    sram_we_o     = '0;
    sram_r_addr_o = '0;
    sram_w_addr_o = '0;
    sram_wdata_o  = '0;
    done_o        = skip_done_q;
    done_id_o     = skip_done_q & skip_id_q;
    unique case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (accept && !acc_skip) state_d = req_we_i[sel] ? ST_WR : ST_RD;
      end
      ST_RD: begin
        sram_re_o = lane_en;
        for (int k = 0; k < NumBanks; k++) sram_r_addr_o[k] = beat_adr;
        beat_d = beat_q + BW'(1);
        if (last_beat) state_d = ST_DRAIN;
      end
      // Last read beat is in flight; done lines up with its rdata_last.
      ST_DRAIN: begin
        done_o    = 1'b1;
        done_id_o = id_q;
        state_d   = ST_IDLE;
      end
      ST_WR: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i) begin
          sram_we_o = lane_en;
          for (int k = 0; k < NumBanks; k++) begin
            sram_w_addr_o[k] = beat_adr;
            sram_wdata_o[k]  = lane_en[k] ? wdata_i[k] : '0;
          end
          beat_d = beat_q + BW'(1);
          if (last_beat) begin
            done_o    = 1'b1;
            done_id_o = id_q;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      vr_q        <= '0;
      vl_q        <= '0;
      id_q        <= 1'b0;
      skip_done_q <= 1'b0;
      skip_id_q   <= 1'b0;
      rvld_q      <= 1'b0;
      rlast_q     <= 1'b0;
      rid_q       <= 1'b0;
      rmask_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      if (accept) begin
        vr_q <= req_vr_i[sel];
        vl_q <= vl_clamp;
        id_q <= sel;
      end
      skip_done_q <= accept && acc_skip;
      skip_id_q   <= sel;
      rvld_q      <= (state_q == ST_RD);
      rlast_q     <= (state_q == ST_RD) && last_beat;
      rid_q       <= (state_q == ST_RD) && id_q;
      rmask_q     <= (state_q == ST_RD) ? lane_en : '0;
    end
  end

  assign rdata_valid_o = rvld_q;
  assign rdata_last_o  = rlast_q;
  assign rdata_id_o    = rid_q;
  assign rdata_mask_o  = rmask_q;

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < NumBanks; k++)
      if (rmask_q[k]) rdata_o[k] = sram_rdata_i[k];
  end

`ifdef VRF_CTRL_STATS_EN
  logic        skip_we_q;
  logic        done_we;
  logic [31:0] rd_ops_q, wr_ops_q;

  assign done_we = skip_done_q ? skip_we_q : (state_q == ST_WR);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      skip_we_q <= 1'b0;
      rd_ops_q  <= '0;
      wr_ops_q  <= '0;
    end else begin
      skip_we_q <= req_we_i[sel];
      if (done_o) begin
        if (done_we) wr_ops_q <= wr_ops_q + 32'd1;
        else         rd_ops_q <= rd_ops_q + 32'd1;
      end
    end
  end

  assign rd_ops_o = rd_ops_q;
  assign wr_ops_o = wr_ops_q;
`endif

endmodule

// File: tb/tb_vrf_ctrl.sv
// Scoreboard bench for vrf_ctrl: element-level VR model plus banked SRAM, randomized and directed ops.
module tb_vrf_ctrl;

  // 24 VRs so that a 5-bit VR index can name registers that do not exist.
  localparam int NV    = 24;
  localparam int EPV   = 32;
  localparam int NB    = 4;
  localparam int DW    = 32;
  localparam int BEATS = EPV / NB;
  localparam int AW    = $clog2(NV * BEATS);
  localparam int VW    = $clog2(NV);
  localparam int LW    = $clog2(EPV) + 1;

  typedef struct {
    logic [NB-1:0]         mask;
    logic [NB-1:0][DW-1:0] data;
    logic                  last;
    logic                  id;
  } rbeat_t;

  typedef struct {
    logic [AW-1:0]         addr;
    logic [NB-1:0]         mask;
    logic [NB-1:0][DW-1:0] data;
  } wbeat_t;

  typedef struct {
    logic id;
    logic with_last;
  } done_t;

  logic                  clk = 1'b0;
  logic                  nrst;
  logic [1:0]            req_valid_i, req_ready_o, req_we_i;
  logic [1:0][VW-1:0]    req_vr_i;
  logic [1:0][LW-1:0]    req_vl_i;
  logic                  wdata_valid_i, wdata_ready_o;
  logic [NB-1:0][DW-1:0] wdata_i, rdata_o, sram_wdata_o, sram_rdata_i;
  logic                  rdata_valid_o, rdata_last_o, rdata_id_o, done_o, done_id_o;
  logic [NB-1:0]         rdata_mask_o, sram_re_o, sram_we_o;
  logic [NB-1:0][AW-1:0] sram_r_addr_o, sram_w_addr_o;

  vrf_ctrl #(.NumVRs(NV), .ElemsPerVR(EPV), .NumBanks(NB), .DataWidth(DW)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_vr_i(req_vr_i), .req_vl_i(req_vl_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rdata_valid_o(rdata_valid_o), .rdata_last_o(rdata_last_o), .rdata_id_o(rdata_id_o),
    .rdata_o(rdata_o), .rdata_mask_o(rdata_mask_o),
    .done_o(done_o), .done_id_o(done_id_o),
    .sram_re_o(sram_re_o), .sram_we_o(sram_we_o),
    .sram_r_addr_o(sram_r_addr_o), .sram_w_addr_o(sram_w_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk = ~clk;

  // Banked SRAM with one-cycle registered read.
  logic [DW-1:0] bmem [NB][NV*BEATS];
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (sram_we_o[k]) bmem[k][sram_w_addr_o[k]] <= sram_wdata_o[k];
      if (sram_re_o[k]) sram_rdata_i[k] <= bmem[k][sram_r_addr_o[k]];
    end
  end

  logic [DW-1:0] mem [NV][EPV];
  bit            prio;
  rbeat_t        rq[$];
  wbeat_t        wq[$];
  done_t         dq[$];
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: element e of VR v, beats of NB elements, vl clamped to EPV.
  task automatic model_op(input bit r, input bit we, input int vr, input int vl,
                          output logic [NB-1:0][DW-1:0] wd [BEATS], output int nbeat);
    int vle; bit act; rbeat_t rb; wbeat_t wb; logic [NB-1:0] m;
    vle   = (vl > EPV) ? EPV : vl;
    act   = (vle > 0) && (vr < NV);
    nbeat = act ? (vle + NB - 1) / NB : 0;
    dq.push_back('{id: r, with_last: act && !we});
    prio  = !r;
    for (int b = 0; b < BEATS; b++) wd[b] = '0;
    for (int b = 0; b < nbeat; b++) begin
      for (int k = 0; k < NB; k++) m[k] = (b * NB + k) < vle;
      if (we) begin
        for (int k = 0; k < NB; k++) wd[b][k] = $urandom;
        wb.addr = AW'(vr * BEATS + b);
        wb.mask = m;
        wb.data = wd[b];
        wq.push_back(wb);
        for (int k = 0; k < NB; k++) if (m[k]) mem[vr][b*NB+k] = wd[b][k];
      end else begin
        rb.mask = m;
        rb.last = (b == nbeat - 1);
        rb.id   = r;
        for (int k = 0; k < NB; k++) rb.data[k] = m[k] ? mem[vr][b*NB+k] : '0;
        rq.push_back(rb);
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((dq.size() > 0 || rq.size() > 0 || wq.size() > 0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      chk("done_timeout", 128'(dq.size()), 0);
      rq.delete(); wq.delete(); dq.delete();
    end
  endtask

  task automatic issue(input bit r, input bit we, input int vr, input int vl,
                       input int st_at, input int st_len);
    logic [NB-1:0][DW-1:0] wd [BEATS];
    int nbeat, n;
    req_valid_i[r] = 1'b1; req_we_i[r] = we;
    req_vr_i[r] = VW'(vr); req_vl_i[r] = LW'(vl);
    #1;
    n = 0;
    while (!req_ready_o[r] && n < 100) begin @(posedge clk); #1; n++; end
    chk("req_grant", req_ready_o[r], 1);
    chk("req_other_idle", req_ready_o[!r], 0);
    model_op(r, we, vr, vl, wd, nbeat);
    @(posedge clk); #1;
    req_valid_i[r] = 1'b0;
    if (we) begin
      for (int b = 0; b < nbeat; b++) begin
        if (b == st_at) repeat (st_len) begin
          wdata_valid_i = 1'b0;
          wdata_i = {$urandom, $urandom, $urandom, $urandom};
          @(posedge clk); #1;
        end
        wdata_valid_i = 1'b1;
        wdata_i = wd[b];
        n = 0;
        while (!wdata_ready_o && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
      end
      wdata_valid_i = 1'b0;
    end
    wait_done();
  endtask

  task automatic issue_pair(input int vr0, input int vl0, input int vr1, input int vl1);
    logic [NB-1:0][DW-1:0] wd [BEATS];
    int nbeat, n; bit g;
    req_valid_i = 2'b11; req_we_i = 2'b00;
    req_vr_i[0] = VW'(vr0); req_vl_i[0] = LW'(vl0);
    req_vr_i[1] = VW'(vr1); req_vl_i[1] = LW'(vl1);
    #1;
    repeat (2) begin
      n = 0;
      while (req_ready_o == 2'b00 && n < 300) begin @(posedge clk); #1; n++; end
      chk("rr_timeout", n < 300, 1);
      g = req_ready_o[1];
      chk("rr_grant", g, prio);
      model_op(g, 1'b0, g ? vr1 : vr0, g ? vl1 : vl0, wd, nbeat);
      @(posedge clk); #1;
      req_valid_i[g] = 1'b0;
      #1;
    end
    wait_done();
  endtask

  task automatic check_zero(input string t);
    chk({t, "_req_ready"}, req_ready_o, 0);
    chk({t, "_wdata_ready"}, wdata_ready_o, 0);
    chk({t, "_rd_ctl"}, {rdata_valid_o, rdata_last_o, rdata_id_o, rdata_mask_o}, 0);
    chk({t, "_rdata"}, rdata_o, 0);
    chk({t, "_done"}, {done_o, done_id_o}, 0);
    chk({t, "_sram_en"}, {sram_re_o, sram_we_o}, 0);
    chk({t, "_sram_addr"}, {sram_r_addr_o, sram_w_addr_o}, 0);
    chk({t, "_sram_wdata"}, sram_wdata_o, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write, read beat or done.
  always @(negedge clk) begin : mon
    rbeat_t rb; wbeat_t wb; done_t d;
    if (nrst) begin
      chk("rw_exclusive", sram_re_o & sram_we_o, 0);
      chk("ready_onehot", &req_ready_o, 0);
      if (|sram_we_o) begin
        if (wq.size() == 0) chk("write_unexpected", sram_we_o, 0);
        else begin
          wb = wq.pop_front();
          chk("wr_mask", sram_we_o, wb.mask);
          for (int k = 0; k < NB; k++) if (wb.mask[k]) begin
            chk("wr_addr", sram_w_addr_o[k], wb.addr);
            chk("wr_data", sram_wdata_o[k], wb.data[k]);
          end
        end
      end
      if (rdata_valid_o) begin
        if (rq.size() == 0) chk("read_unexpected", 1, 0);
        else begin
          rb = rq.pop_front();
          chk("rd_mask", rdata_mask_o, rb.mask);
          chk("rd_data", rdata_o, rb.data);
          chk("rd_last", rdata_last_o, rb.last);
          chk("rd_id", rdata_id_o, rb.id);
        end
      end else begin
        chk("rd_idle_data", rdata_o, 0);
        chk("rd_idle_mask", rdata_mask_o, 0);
      end
      if (done_o) begin
        if (dq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          d = dq.pop_front();
          chk("done_id", done_id_o, d.id);
          if (d.with_last) chk("done_with_last", {rdata_valid_o, rdata_last_o}, 2'b11);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [NB-1:0][DW-1:0] wd [BEATS];
    int nbeat, n;
    nrst = 1'b0;
    req_valid_i = 2'b11; req_we_i = '0; req_vr_i = '0; req_vl_i = '0;
    wdata_valid_i = 1'b0; wdata_i = '0;
    for (int v = 0; v < NV; v++) for (int e = 0; e < EPV; e++) mem[v][e] = '0;
    for (int k = 0; k < NB; k++) for (int a = 0; a < NV*BEATS; a++) bmem[k][a] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst0");
    req_valid_i = 2'b00;
    prio = 1'b0;
    nrst = 1'b1;
    @(posedge clk); #1;

    // Fill every VR so later reads see known data.
    for (int v = 0; v < NV; v++) issue(v % 2, 1'b1, v, EPV, 8, 0);

    issue(0, 1'b1, 3, 32, 8, 0);    // 8 full beats at addresses 24..31
    issue(1, 1'b0, 3, 10, 8, 0);    // masks F, F, 3
    issue_pair(4, 32, 5, 7);        // grants 0 then 1
    issue_pair(6, 1, 3, 32);        // grants 0 then 1 again
    issue(0, 1'b1, 5, 32, 3, 5);    // 5-cycle wdata stall before beat 3
    issue(1, 1'b1, 7, 0, 8, 0);
    issue(0, 1'b0, 7, 0, 8, 0);
    issue(1, 1'b0, 7, 40, 8, 0);
    issue(0, 1'b1, 9, 40, 2, 2);
    issue(1, 1'b0, 9, 40, 8, 0);
    issue(0, 1'b0, 30, 16, 8, 0);   // VR index beyond NV
    issue(1, 1'b1, 26, 8, 8, 0);

    repeat (40)
      issue($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, NV + 7),
            $urandom_range(0, EPV + 8), $urandom_range(0, 7), $urandom_range(0, 3));

    // Abort a long read during its fifth issue cycle.
    req_valid_i[1] = 1'b1; req_we_i[1] = 1'b0;
    req_vr_i[1] = VW'(8); req_vl_i[1] = LW'(32);
    #1;
    n = 0;
    while (!req_ready_o[1] && n < 100) begin @(posedge clk); #1; n++; end
    chk("rst_op_grant", req_ready_o[1], 1);
    model_op(1'b1, 1'b0, 8, 32, wd, nbeat);
    @(posedge clk); #1;
    req_valid_i[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    req_vr_i[0] = VW'(2); req_vl_i[0] = LW'(4);
    req_valid_i = 2'b11;
    nrst = 1'b0;
    #1;
    check_zero("rst_mid");
    rq.delete(); wq.delete(); dq.delete();
    prio = 1'b0;
    @(posedge clk); #1;
    check_zero("rst_hold");
    req_valid_i = 2'b00;
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue_pair(2, 32, 4, 5);        // requester 0 first after reset

    chk("queues_empty", 128'(rq.size() + wq.size() + dq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
